// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared TMDS definitions for the channel decoder (and any encoder bench):
//   - the four control-token characters, as seen after alignment
//   - alignment state enum {SEARCH, LOCKED}
//   - token matcher, 10b->8b data decode and a ones counter
// No ports; imported with "import tmds_pkg::*;".
// -----------------------------------------------------------------------------
package tmds_pkg;

    // Control tokens, bit 0 first on the wire.
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    typedef struct packed {
        logic       is_token;
        logic [1:0] ctrl;      // {C1,C0}
    } token_match_t;

    function automatic token_match_t token_match(input logic [9:0] word);
        token_match_t m;
        m.is_token = 1'b1;
        m.ctrl     = 2'b00;
        case (word)
            CTRL_TOKEN_00: m.ctrl = 2'b00;
            CTRL_TOKEN_01: m.ctrl = 2'b01;
            CTRL_TOKEN_10: m.ctrl = 2'b10;
            CTRL_TOKEN_11: m.ctrl = 2'b11;
            default:       m.is_token = 1'b0;
        endcase
        return m;
    endfunction

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    function automatic logic [7:0] tmds_decode(input logic [9:0] word);
        logic [7:0] d;
        logic [7:0] q;
        d    = word[9] ? ~word[7:0] : word[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    function automatic logic [3:0] num_of_ones(input logic [9:0] word);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, word[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// -----------------------------------------------------------------------------
// tmds_word_aligner
// Finds the TMDS character boundary by bit-slip search on control tokens and
// registers the aligned word (pipeline stage 1).
//   clk, rst        : clock, asynchronous active-high reset
//   char_in[9:0]    : raw deserializer word, bit 0 first on the wire
//   char_valid      : qualifier; low freezes every register here
//   aligned_o[9:0]  : registered aligned character
//   is_token_o      : registered "aligned word is a control token"
//   token_val_o[1:0]: registered {C1,C0} of that token
//   locked_o        : FSM is in LOCKED (state after the registered word)
//   bit_offset_o    : current slip offset 0..9
//   state_o         : FSM state, exposed for observation
// -----------------------------------------------------------------------------
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [9:0]   char_in,
    input  logic         char_valid,
    output logic [9:0]   aligned_o,
    output logic         is_token_o,
    output logic [1:0]   token_val_o,
    output logic         locked_o,
    output logic [3:0]   bit_offset_o,
    output align_state_t state_o
);

    localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
    localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
    localparam int IDLE_W = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_TOKENS);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [IDLE_W-1:0] IDLE_LOSS = IDLE_W'(LOSS_TIMEOUT);

    align_state_t      state_q, state_d;
    logic [RUN_W-1:0]  token_run_q, token_run_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]        bit_offset_q, bit_offset_d;

    logic [9:0]        w_prev_q, w_prev_d;
    logic [9:0]        aligned_q, aligned_d;
    logic              is_token_q, is_token_d;
    logic [1:0]        token_val_q, token_val_d;

    logic [19:0]       window;
    logic [9:0]        aligned_c;
    token_match_t      match_c;
    logic [RUN_W-1:0]  run_inc;
    logic [IDLE_W-1:0] idle_inc;

    // Older word in the low half: offset k selects window[k+9:k].
    always_comb begin
        window      = {char_in, w_prev_q};
        aligned_c   = 10'(window >> bit_offset_q);
        match_c     = token_match(aligned_c);

        w_prev_d    = w_prev_q;
        aligned_d   = aligned_q;
        is_token_d  = is_token_q;
        token_val_d = token_val_q;
        if (char_valid) begin
            w_prev_d    = char_in;
            aligned_d   = aligned_c;
            is_token_d  = match_c.is_token;
            token_val_d = match_c.ctrl;
        end
    end

    // State register (with counters).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            token_run_q  <= '0;
            win_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            bit_offset_q <= 4'd0;
            w_prev_q     <= '0;
            aligned_q    <= '0;
            is_token_q   <= 1'b0;
            token_val_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            token_run_q  <= token_run_d;
            win_cnt_q    <= win_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            bit_offset_q <= bit_offset_d;
            w_prev_q     <= w_prev_d;
            aligned_q    <= aligned_d;
            is_token_q   <= is_token_d;
            token_val_q  <= token_val_d;
        end
    end

    // Next-state logic. Lock wins over a slip on the same character.
    always_comb begin
        state_d      = state_q;
        token_run_d  = token_run_q;
        win_cnt_d    = win_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        bit_offset_d = bit_offset_q;
        run_inc      = token_run_q + RUN_W'(1);
        idle_inc     = idle_cnt_q + IDLE_W'(1);

        if (char_valid) begin
            case (state_q)
                SEARCH: begin
                    if (match_c.is_token && run_inc == RUN_LOCK) begin
                        state_d     = LOCKED;
                        token_run_d = '0;
                        win_cnt_d   = '0;
                        idle_cnt_d  = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        bit_offset_d = (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;
                        token_run_d  = '0;
                        win_cnt_d    = '0;
                        idle_cnt_d   = '0;
                    end else begin
                        token_run_d = match_c.is_token ? run_inc : '0;
                        win_cnt_d   = win_cnt_q + WIN_W'(1);
                    end
                end
                LOCKED: begin
                    if (match_c.is_token) begin
                        idle_cnt_d = '0;
                    end else if (idle_inc == IDLE_LOSS) begin
                        // Offset is kept: the link most likely just resumes.
                        state_d     = SEARCH;
                        token_run_d = '0;
                        win_cnt_d   = '0;
                        idle_cnt_d  = '0;
                    end else begin
                        idle_cnt_d = idle_inc;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        aligned_o    = aligned_q;
        is_token_o   = is_token_q;
        token_val_o  = token_val_q;
        locked_o     = (state_q == LOCKED);
        bit_offset_o = bit_offset_q;
        state_o      = state_q;
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_decoder
// One TMDS receive channel: word alignment (tmds_word_aligner, stage 1) then
// control/data decode into registered outputs (stage 2).
//   pixelClock      : sole clock, one character per cycle when charValid
//   reset           : asynchronous, active-high
//   charIn[9:0]     : raw deserializer word, bit 0 first on the wire
//   charValid       : qualifier; low stalls the whole block
//   pixelOut[7:0]   : decoded byte (holds across control periods)
//   controlOut[1:0] : {C1,C0} of the last control token
//   deOut           : 1 = data character, 0 = control token
//   outValid        : charValid delayed by two cycles
//   locked          : alignment achieved, aligned with the outputs
//   bitOffset[3:0]  : current slip offset 0..9
// Optional build macro TMDS_DISPARITY_CHECK_EN adds
//   disparityError  : one-cycle pulse when running |disparity| exceeds 16
// -----------------------------------------------------------------------------
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       pixelClock,
    input  logic       reset,
    input  logic [9:0] charIn,
    input  logic       charValid,
    output logic [7:0] pixelOut,
    output logic [1:0] controlOut,
    output logic       deOut,
    output logic       outValid,
    output logic       locked,
    output logic [3:0] bitOffset
`ifdef TMDS_DISPARITY_CHECK_EN
    ,
    output logic       disparityError
`endif
);

    logic [9:0]   aligner_word;
    logic         aligner_is_token;
    logic [1:0]   aligner_token_val;
    logic         aligner_locked;
    align_state_t aligner_state;

    tmds_word_aligner #(
        .LOCK_TOKENS  (LOCK_TOKENS),
        .SEARCH_WINDOW(SEARCH_WINDOW),
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) u_aligner (
        .clk         (pixelClock),
        .rst         (reset),
        .char_in     (charIn),
        .char_valid  (charValid),
        .aligned_o   (aligner_word),
        .is_token_o  (aligner_is_token),
        .token_val_o (aligner_token_val),
        .locked_o    (aligner_locked),
        .bit_offset_o(bitOffset),
        .state_o     (aligner_state)
    );

    logic       valid_d1_q, valid_d1_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] pixel_q, pixel_d;
    logic [1:0] control_q, control_d;
    logic       de_q, de_d;
    logic       locked_out_q, locked_out_d;

    // Stage 2 advances only when stage 1 holds a freshly captured character.
    always_comb begin
        valid_d1_d   = charValid;
        out_valid_d  = valid_d1_q;
        pixel_d      = pixel_q;
        control_d    = control_q;
        de_d         = de_q;
        locked_out_d = locked_out_q;
        if (valid_d1_q) begin
            locked_out_d = aligner_locked;
            if (aligner_state != LOCKED) begin
                pixel_d   = 8'h00;
                control_d = 2'b00;
                de_d      = 1'b0;
            end else if (aligner_is_token) begin
                de_d      = 1'b0;
                control_d = aligner_token_val;
            end else begin
                de_d      = 1'b1;
                pixel_d   = tmds_decode(aligner_word);
            end
        end
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            valid_d1_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            pixel_q      <= 8'h00;
            control_q    <= 2'b00;
            de_q         <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            valid_d1_q   <= valid_d1_d;
            out_valid_q  <= out_valid_d;
            pixel_q      <= pixel_d;
            control_q    <= control_d;
            de_q         <= de_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign pixelOut   = pixel_q;
    assign controlOut = control_q;
    assign deOut      = de_q;
    assign outValid   = out_valid_q;
    assign locked     = locked_out_q;

`ifdef TMDS_DISPARITY_CHECK_EN
    // Running disparity: each data character adds 2*ones-10. The count never
    // exceeds 16+10 in magnitude, so 6 signed bits are enough.
    logic signed [5:0] disp_cnt_q, disp_cnt_d;
    logic              disp_err_q, disp_err_d;
    logic signed [5:0] disp_sum;

    always_comb begin
        disp_cnt_d = disp_cnt_q;
        disp_err_d = 1'b0;
        disp_sum   = disp_cnt_q + $signed({1'b0, num_of_ones(aligner_word), 1'b0}) - 6'sd10;
        if (valid_d1_q) begin
            if (aligner_state != LOCKED || aligner_is_token) begin
                disp_cnt_d = 6'sd0;
            end else if (disp_sum > 6'sd16 || disp_sum < -6'sd16) begin
                disp_err_d = 1'b1;
                disp_cnt_d = 6'sd0;
            end else begin
                disp_cnt_d = disp_sum;
            end
        end
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            disp_cnt_q <= 6'sd0;
            disp_err_q <= 1'b0;
        end else begin
            disp_cnt_q <= disp_cnt_d;
            disp_err_q <= disp_err_d;
        end
    end

    assign disparityError = disp_err_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_channel_decoder
// Directed bench for tmds_channel_decoder: lock at offset 0, data/control
// decode, loss of lock and relock, stalled lock sequence, slip search to
// offset 3, resets mid-search and mid-lock, and (with
// TMDS_DISPARITY_CHECK_EN) the disparity pulse.
// -----------------------------------------------------------------------------
module tb_tmds_channel_decoder;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] DATA_EF = 10'b0110100101;  // decodes to 0xEF

    logic       pixelClock;
    logic       reset;
    logic [9:0] charIn;
    logic       charValid;
    logic [7:0] pixelOut;
    logic [1:0] controlOut;
    logic       deOut;
    logic       outValid;
    logic       locked;
    logic [3:0] bitOffset;
`ifdef TMDS_DISPARITY_CHECK_EN
    logic       disparityError;
`endif

    int checks = 0;
    int errors = 0;

    // Expected {deOut, controlOut, pixelOut}.
    logic [10:0] exp_q[$];
    logic [9:0]  prev_c;

    tmds_channel_decoder dut (
        .pixelClock(pixelClock),
        .reset     (reset),
        .charIn    (charIn),
        .charValid (charValid),
        .pixelOut  (pixelOut),
        .controlOut(controlOut),
        .deOut     (deOut),
        .outValid  (outValid),
        .locked    (locked),
        .bitOffset (bitOffset)
`ifdef TMDS_DISPARITY_CHECK_EN
        ,
        .disparityError(disparityError)
`endif
    );

    // ---------------- clock ----------------
    initial pixelClock = 1'b0;
    always #5 pixelClock = ~pixelClock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic v, input logic [9:0] ch);
        @(negedge pixelClock);
        charValid = v;
        charIn    = ch;
        @(posedge pixelClock);
        #1;
    endtask

    // Serial stream whose character boundary sits 3 bits into each word.
    task automatic step_shift(input logic [9:0] c);
        step(1'b1, {c[6:0], prev_c[9:7]});
        prev_c = c;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pixel"},  32'(pixelOut),   32'h0);
        check({tag, "_ctrl"},   32'(controlOut), 32'h0);
        check({tag, "_de"},     32'(deOut),      32'h0);
        check({tag, "_valid"},  32'(outValid),   32'h0);
        check({tag, "_locked"}, 32'(locked),     32'h0);
        check({tag, "_offset"}, 32'(bitOffset),  32'h0);
`ifdef TMDS_DISPARITY_CHECK_EN
        check({tag, "_disp"},   32'(disparityError), 32'h0);
`endif
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge pixelClock);
        reset     = 1'b1;
        charValid = 1'b0;
        #1;
        check_zero_outputs(tag);
        @(negedge pixelClock);
        reset = 1'b0;
    endtask

    // Drives 12 TOK00 from a SEARCH state at offset 0; the 8th token is
    // aligned on drive 9 and reaches the outputs on drive 10.
    task automatic lock_run(input string tag);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, TOK00);
            if (i == 9)  check({tag, "_pre"}, 32'(locked), 32'h0);
            if (i == 10) begin
                check({tag, "_locked"}, 32'(locked),     32'h1);
                check({tag, "_ctrl"},   32'(controlOut), 32'h0);
                check({tag, "_de"},     32'(deOut),      32'h0);
                check({tag, "_offset"}, 32'(bitOffset),  32'h0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [9:0]  vec_in [7];
    logic [10:0] vec_exp[7];

    initial begin
        vec_in[0] = 10'b0100000000; vec_exp[0] = {1'b1, 2'b00, 8'h00};
        vec_in[1] = 10'b1000000000; vec_exp[1] = {1'b1, 2'b00, 8'hFF};
        vec_in[2] = 10'b0100000001; vec_exp[2] = {1'b1, 2'b00, 8'h03};
        vec_in[3] = 10'b0000000001; vec_exp[3] = {1'b1, 2'b00, 8'hFD};
        vec_in[4] = DATA_EF;        vec_exp[4] = {1'b1, 2'b00, 8'hEF};
        vec_in[5] = TOK10;          vec_exp[5] = {1'b0, 2'b10, 8'hEF};
        vec_in[6] = TOK00;          vec_exp[6] = {1'b0, 2'b00, 8'hEF};

        reset     = 1'b1;
        charValid = 1'b0;
        charIn    = '0;
        prev_c    = TOK00;
        repeat (2) @(posedge pixelClock);
        #1;
        check_zero_outputs("reset");
        @(negedge pixelClock);
        reset = 1'b0;

        // Lock at offset 0, with outValid following charValid by two edges.
        step(1'b1, TOK00);
        check("ov_first", 32'(outValid), 32'h0);
        step(1'b1, TOK00);
        check("ov_second", 32'(outValid), 32'h1);
        for (int i = 3; i <= 12; i++) begin
            step(1'b1, TOK00);
            if (i == 9)  check("lock_pre", 32'(locked), 32'h0);
            if (i == 10) begin
                check("lock_locked", 32'(locked),     32'h1);
                check("lock_ctrl",   32'(controlOut), 32'h0);
                check("lock_de",     32'(deOut),      32'h0);
                check("lock_offset", 32'(bitOffset),  32'h0);
            end
        end

        // Decode while locked: each character shows up two edges later.
        for (int i = 0; i < 9; i++) begin
            logic [10:0] exp_word;
            if (i < 7) begin
                step(1'b1, vec_in[i]);
                exp_q.push_back(vec_exp[i]);
            end else begin
                step(1'b1, TOK00);
            end
            if (i == 1) check("dec_latency", 32'(deOut), 32'h0);
            if (i >= 2) begin
                exp_word = exp_q.pop_front();
                check($sformatf("dec%0d", i - 2), 32'({deOut, controlOut, pixelOut}), 32'(exp_word));
                check($sformatf("dec%0d_locked", i - 2), 32'(locked), 32'h1);
            end
        end

        // Loss of lock after 4096 data characters.
        for (int i = 1; i <= 4098; i++) begin
            step(1'b1, DATA_EF);
            if (i == 4097) begin
                check("loss_pre_locked", 32'(locked),   32'h1);
                check("loss_pre_pixel",  32'(pixelOut), 32'hEF);
            end
        end
        check("loss_locked", 32'(locked),     32'h0);
        check("loss_pixel",  32'(pixelOut),   32'h0);
        check("loss_de",     32'(deOut),      32'h0);
        check("loss_ctrl",   32'(controlOut), 32'h0);
        check("loss_offset", 32'(bitOffset),  32'h0);
        lock_run("relock");

        // Reset mid-lock, then lock with charValid toggling; idle cycles
        // carry a data character that must be ignored.
        pulse_reset("rst_lock");
        for (int i = 1; i <= 20; i++) begin
            if (i % 2 == 1) step(1'b1, TOK00);
            else            step(1'b0, DATA_EF);
            if (i == 17) begin
                check("stall_pre",    32'(locked),   32'h0);
                check("stall_pre_ov", 32'(outValid), 32'h0);
            end
            if (i == 18) begin
                check("stall_locked", 32'(locked),   32'h1);
                check("stall_ov",     32'(outValid), 32'h1);
            end
            if (i == 19) begin
                check("stall_hold",  32'(locked),   32'h1);
                check("stall_ov_lo", 32'(outValid), 32'h0);
            end
        end

        // Slip search: boundary 3 bits into each word. Reset once mid-search.
        pulse_reset("rst_pre_slip");
        prev_c = TOK00;
        for (int i = 1; i <= 2100; i++) begin
            step_shift(TOK00);
            if (i == 2047) check("slip_a0", 32'(bitOffset), 32'h0);
            if (i == 2048) check("slip_a1", 32'(bitOffset), 32'h1);
        end
        pulse_reset("rst_search");
        prev_c = TOK00;
        for (int i = 1; i <= 6153; i++) begin
            step_shift(TOK00);
            if (i == 2048) check("slip_b1", 32'(bitOffset), 32'h1);
            if (i == 4095) check("slip_b1_end", 32'(bitOffset), 32'h1);
            if (i == 4096) check("slip_b2", 32'(bitOffset), 32'h2);
            if (i == 6143) check("slip_b2_end", 32'(bitOffset), 32'h2);
            if (i == 6144) check("slip_b3", 32'(bitOffset), 32'h3);
            if (i == 6152) check("slip_pre", 32'(locked), 32'h0);
        end
        check("slip_locked", 32'(locked),     32'h1);
        check("slip_ctrl",   32'(controlOut), 32'h0);
        check("slip_de",     32'(deOut),      32'h0);
        check("slip_offset", 32'(bitOffset),  32'h3);
        step_shift(DATA_EF);
        step_shift(TOK10);
        step_shift(TOK00);
        check("slip_dec_de",    32'(deOut),    32'h1);
        check("slip_dec_pixel", 32'(pixelOut), 32'hEF);
        step_shift(TOK00);
        check("slip_tok_de",   32'(deOut),      32'h0);
        check("slip_tok_ctrl", 32'(controlOut), 32'h2);

        pulse_reset("rst_midlock");

`ifdef TMDS_DISPARITY_CHECK_EN
        lock_run("disp_lock");
        step(1'b1, 10'h3FF);
        step(1'b1, 10'h3FF);
        step(1'b1, TOK00);
        check("disp_first",  32'(disparityError), 32'h0);
        check("disp_de",     32'(deOut),          32'h1);
        check("disp_pixel",  32'(pixelOut),       32'h00);
        step(1'b1, TOK00);
        check("disp_second", 32'(disparityError), 32'h1);
        step(1'b1, TOK00);
        check("disp_after",  32'(disparityError), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
